core_run_scheduler: RTL and testbench
=====================================

Name: core_run_scheduler

Overview:
- Host-command-driven sequencer for the processor-under-test.
- Decides when the core receives clock edges (clk_core_en, consumed by the top-level clock gate that produces clk_core) and when reset_core is held.
- Supports run-N-cycles, run-to-breakpoint and step-N-instructions, terminating on RVFI trap/halt.
- Sits between the host command decoder and the core's clock/reset, observing the core's RVFI retirement stream.

Parameters:
- CNT_WIDTH, 32, width of the cycle_count and retired_count counters.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  host command strobe
- cmd_ready  out  1  scheduler can accept a command
- cmd_op  in  3  opcode: 0 NOP, 1 RESET_CORE, 2 RUN_CYCLES, 3 RUN_UNTIL_PC, 4 STEP_INSN, 5 HALT, 6 CLEAR_COUNT
- cmd_arg  in  32  operand: cycles, target PC, instruction count, or reset length
- clk_core_en  out  1  registered core clock enable
- reset_core  out  1  active-high core reset
- rvfi_valid  in  1  instruction retired
- rvfi_trap  in  1  retired instruction trapped
- rvfi_halt  in  1  core halted
- rvfi_pc_wdata  in  32  next PC of the retired instruction
- busy  out  1  state is not IDLE
- done_valid  out  1  sticky: last run finished
- done_cause  out  2  0 count exhausted, 1 breakpoint, 2 trap/rvfi_halt, 3 host HALT
- cmd_error  out  1  one-cycle pulse: command dropped
- cycle_count  out  CNT_WIDTH  core-enabled cycles since last clear
- retired_count  out  CNT_WIDTH  retirements since last clear

Behaviour:
- Reset values: state IDLE; clk_core_en 0; reset_core 1; busy 0; done_valid 0; done_cause 0; cmd_error 0; counters 0; cmd_ready 1. The core stays in reset until a RESET_CORE command completes.
- Handshake: a command is accepted when cmd_valid && cmd_ready. cmd_ready is 1 in IDLE and RUN_* states and 0 in RESETTING.
- Any command accepted in IDLE clears done_valid on the next cycle.
- States: IDLE, RESETTING, RUN_CYC, RUN_BP, RUN_INSN. All outputs are registered; effects appear the cycle after acceptance (latency 1).
- RESET_CORE:
  - Load len = cmd_arg[7:0], with 0 treated as 1.
  - Enter RESETTING for exactly len cycles with reset_core=1 and clk_core_en=1.
  - Then reset_core=0, clk_core_en=0, return to IDLE. Does not set done_valid. Counters do not advance.
- RUN_CYCLES N:
  - clk_core_en=1 for exactly N consecutive cycles, then IDLE with done_valid=1, cause 0.
  - N=0: no enable cycle; done_valid=1, cause 0, on the next cycle.
- RUN_UNTIL_PC T: clk_core_en=1 until a cycle with clk_core_en && rvfi_valid && rvfi_pc_wdata==T. clk_core_en=0 from the following cycle; cause 1.
- STEP_INSN K:
  - clk_core_en=1 until K retirements are seen; the enable drops the cycle after the K-th retirement; cause 0.
  - K=0 behaves as N=0.
- Termination on core events: in any RUN_* state, a cycle with clk_core_en && rvfi_valid && (rvfi_trap || rvfi_halt) ends the run; cause 2.
- HALT: in a RUN_* state, ends the run next cycle with cause 3. In IDLE it is a no-op and does not set done_valid.
- Other opcodes in RUN_* states (RESET_CORE, RUN_*, STEP_INSN, CLEAR_COUNT): dropped; cmd_error pulses for one cycle; the run continues. Opcode 7 in any state: dropped with cmd_error. NOP: no effect anywhere.
- Simultaneous termination events in one cycle, priority: trap/halt (2) > breakpoint (1) > count exhausted (0) > host HALT (3). Exactly one cause is recorded.
- Counters:
  - cycle_count increments on every cycle with clk_core_en=1 in a RUN_* state.
  - retired_count increments on clk_core_en && rvfi_valid.
  - Both wrap modulo 2^CNT_WIDTH.
  - CLEAR_COUNT (IDLE only) zeroes both the next cycle.
  - The internal down-counters for N and K are 32-bit and independent of CNT_WIDTH.
- reset deassertion mid-run is irrelevant; reset assertion at any time returns everything to reset values immediately (asynchronous).

Test Plan:
- Reset, then RESET_CORE arg=3 -> reset_core=1 and clk_core_en=1 for exactly 3 cycles, then reset_core=0 and clk_core_en=0; cmd_ready=0 during those cycles; done_valid stays 0.
- RUN_CYCLES 10 after core reset -> clk_core_en high exactly 10 cycles; cycle_count=10; done_valid=1, done_cause=0; RUN_CYCLES 0 -> done with cycle_count unchanged.
- RUN_UNTIL_PC 0x0000_0040 with retirements at PC 0x04,0x08,...,0x40 -> clk_core_en low the cycle after the 0x40 retirement; cause 1; retired_count=16.
- STEP_INSN 3 with a trap on the 2nd retirement -> stops after the 2nd retirement; cause 2; retired_count=2. Repeat with trap and breakpoint in the same cycle -> cause 2.
- RUN_CYCLES 1000, RUN_CYCLES 5 sent mid-run -> cmd_error pulse, run continues. Then HALT -> clk_core_en low the next cycle, cause 3. CLEAR_COUNT -> both counters 0.
- Assert reset during RUN_BP -> clk_core_en=0, reset_core=1, counters 0, state IDLE immediately.

Source files
------------

// File: rtl/core_run_scheduler.sv
// rtl/core_run_scheduler.sv - host-command sequencer gating the core clock enable and reset
module core_run_scheduler #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_op,
    input  logic [31:0]          cmd_arg,
    output logic                 clk_core_en,
    output logic                 reset_core,
    input  logic                 rvfi_valid,
    input  logic                 rvfi_trap,
    input  logic                 rvfi_halt,
    input  logic [31:0]          rvfi_pc_wdata,
    output logic                 busy,
    output logic                 done_valid,
    output logic [1:0]           done_cause,
    output logic                 cmd_error,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] retired_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESETTING,
        S_RUN_CYC,
        S_RUN_BP,
        S_RUN_INSN
    } state_t;

    localparam logic [2:0] OP_NOP         = 3'd0;
    localparam logic [2:0] OP_RESET_CORE  = 3'd1;
    localparam logic [2:0] OP_RUN_CYCLES  = 3'd2;
    localparam logic [2:0] OP_RUN_UNTIL   = 3'd3;
    localparam logic [2:0] OP_STEP_INSN   = 3'd4;
    localparam logic [2:0] OP_HALT        = 3'd5;
    localparam logic [2:0] OP_CLEAR_COUNT = 3'd6;

    localparam logic [1:0] CAUSE_COUNT = 2'd0;
    localparam logic [1:0] CAUSE_BP    = 2'd1;
    localparam logic [1:0] CAUSE_TRAP  = 2'd2;
    localparam logic [1:0] CAUSE_HALT  = 2'd3;

    state_t                 state, state_d;
    logic [31:0]            remain, remain_d;
    logic [31:0]            target, target_d;
    logic                   en_d, rc_d, dv_d, err_d;
    logic [1:0]             dc_d;
    logic [CNT_WIDTH-1:0]   cyc_d, ret_d;
    logic                   accept, retire;
    logic                   trap_ev, bp_ev, cnt_ev, halt_ev;

    // Ready and busy are pure decodes of the registered state.
    assign cmd_ready = (state != S_RESETTING);
    assign busy      = (state != S_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign retire    = clk_core_en && rvfi_valid;

    // Next-state and next-output computation; remain doubles as reset length and run down-counter.
    always_comb begin
        state_d  = state;
        remain_d = remain;
        target_d = target;
        en_d     = clk_core_en;
        rc_d     = reset_core;
        dv_d     = done_valid;
        dc_d     = done_cause;
        err_d    = 1'b0;
        cyc_d    = cycle_count;
        ret_d    = retired_count;
        trap_ev  = 1'b0;
        bp_ev    = 1'b0;
        cnt_ev   = 1'b0;
        halt_ev  = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept && cmd_op != OP_NOP) begin
                    dv_d = 1'b0;
                    case (cmd_op)
                        OP_RESET_CORE: begin
                            state_d  = S_RESETTING;
                            remain_d = (cmd_arg[7:0] == 8'd0) ? 32'd1 : {24'd0, cmd_arg[7:0]};
                            en_d     = 1'b1;
                            rc_d     = 1'b1;
                        end
                        OP_RUN_CYCLES, OP_STEP_INSN: begin
                            if (cmd_arg == 32'd0) begin
                                dv_d = 1'b1;
                                dc_d = CAUSE_COUNT;
                            end else begin
                                state_d  = (cmd_op == OP_RUN_CYCLES) ? S_RUN_CYC : S_RUN_INSN;
                                remain_d = cmd_arg;
                                en_d     = 1'b1;
                            end
                        end
                        OP_RUN_UNTIL: begin
                            state_d  = S_RUN_BP;
                            target_d = cmd_arg;
                            en_d     = 1'b1;
                        end
                        OP_CLEAR_COUNT: begin
                            cyc_d = '0;
                            ret_d = '0;
                        end
                        OP_HALT: begin
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_RESETTING: begin
                if (remain == 32'd1) begin
                    state_d = S_IDLE;
                    en_d    = 1'b0;
                    rc_d    = 1'b0;
                end else begin
                    remain_d = remain - 32'd1;
                end
            end
            default: begin
                if (clk_core_en) begin
                    cyc_d = cycle_count + 1'b1;
                end
                if (retire) begin
                    ret_d = retired_count + 1'b1;
                end
                if (state == S_RUN_CYC || (state == S_RUN_INSN && retire)) begin
                    remain_d = remain - 32'd1;
                    cnt_ev   = (remain == 32'd1);
                end
                trap_ev = retire && (rvfi_trap || rvfi_halt);
                bp_ev   = (state == S_RUN_BP) && retire && (rvfi_pc_wdata == target);
                halt_ev = accept && (cmd_op == OP_HALT);
                if (accept && cmd_op != OP_NOP && cmd_op != OP_HALT) begin
                    err_d = 1'b1;
                end
                if (trap_ev || bp_ev || cnt_ev || halt_ev) begin
                    state_d = S_IDLE;
                    en_d    = 1'b0;
                    dv_d    = 1'b1;
                    if (trap_ev)     dc_d = CAUSE_TRAP;
                    else if (bp_ev)  dc_d = CAUSE_BP;
                    else if (cnt_ev) dc_d = CAUSE_COUNT;
                    else             dc_d = CAUSE_HALT;
                end
            end
        endcase
    end

    // State and output registers; the core is held in reset from power-up.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            remain        <= 32'd0;
            target        <= 32'd0;
            clk_core_en   <= 1'b0;
            reset_core    <= 1'b1;
            done_valid    <= 1'b0;
            done_cause    <= 2'd0;
            cmd_error     <= 1'b0;
            cycle_count   <= '0;
            retired_count <= '0;
        end else begin
            state         <= state_d;
            remain        <= remain_d;
            target        <= target_d;
            clk_core_en   <= en_d;
            reset_core    <= rc_d;
            done_valid    <= dv_d;
            done_cause    <= dc_d;
            cmd_error     <= err_d;
            cycle_count   <= cyc_d;
            retired_count <= ret_d;
        end
    end

endmodule

// File: tb/tb_core_run_scheduler.sv
// tb/tb_core_run_scheduler.sv - directed self-checking bench for core_run_scheduler
module tb_core_run_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [31:0] cmd_arg = 32'd0;
    logic        clk_core_en;
    logic        reset_core;
    logic        rvfi_valid = 1'b0;
    logic        rvfi_trap = 1'b0;
    logic        rvfi_halt = 1'b0;
    logic [31:0] rvfi_pc_wdata = 32'd0;
    logic        busy;
    logic        done_valid;
    logic [1:0]  done_cause;
    logic        cmd_error;
    logic [31:0] cycle_count;
    logic [31:0] retired_count;

    int total = 0;
    int bad = 0;

    core_run_scheduler #(.CNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .clk_core_en(clk_core_en), .reset_core(reset_core),
        .rvfi_valid(rvfi_valid), .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt),
        .rvfi_pc_wdata(rvfi_pc_wdata), .busy(busy), .done_valid(done_valid),
        .done_cause(done_cause), .cmd_error(cmd_error), .cycle_count(cycle_count),
        .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    // Drive one command for one cycle; returns at the negedge after acceptance.
    task automatic send(input logic [2:0] op, input logic [31:0] arg);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_arg   = 32'd0;
    endtask

    // Count consecutive sampled cycles with the core enable high, bounded.
    task automatic count_en(output int n);
        n = 0;
        while (clk_core_en === 1'b1 && n < 2000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (clk_core_en !== 1'b0) begin bad++; $display("FAIL rst_en got=%b want=0", clk_core_en); end
        total++; if (reset_core !== 1'b1) begin bad++; $display("FAIL rst_reset_core got=%b want=1", reset_core); end
        total++; if ({busy, done_valid, done_cause, cmd_error, cmd_ready} !== 6'b000001) begin
            bad++; $display("FAIL rst_flags got=%b want=000001", {busy, done_valid, done_cause, cmd_error, cmd_ready}); end
        total++; if (cycle_count !== 32'd0 || retired_count !== 32'd0) begin
            bad++; $display("FAIL rst_counters got=%0d/%0d want=0/0", cycle_count, retired_count); end
        reset = 1'b1;
    endtask

    task automatic test_reset_core;
        int n;
        int ready_bad;
        send(3'd1, 32'd3);
        n = 0;
        ready_bad = 0;
        while (clk_core_en === 1'b1 && n < 100) begin
            if (reset_core !== 1'b1 || cmd_ready !== 1'b0) ready_bad++;
            n++;
            @(negedge clk);
        end
        total++; if (n !== 3) begin bad++; $display("FAIL rc3_len got=%0d want=3", n); end
        total++; if (ready_bad !== 0) begin bad++; $display("FAIL rc3_hold got=%0d want=0", ready_bad); end
        total++; if (reset_core !== 1'b0 || cmd_ready !== 1'b1 || done_valid !== 1'b0) begin
            bad++; $display("FAIL rc3_after got=%b%b%b want=010", reset_core, cmd_ready, done_valid); end
        send(3'd1, 32'h100);
        count_en(n);
        total++; if (n !== 1) begin bad++; $display("FAIL rc0_len got=%0d want=1", n); end
        total++; if (cycle_count !== 32'd0) begin bad++; $display("FAIL rc_cyc got=%0d want=0", cycle_count); end
    endtask

    task automatic test_run_cycles;
        int n;
        send(3'd6, 32'd0);
        send(3'd2, 32'd10);
        total++; if (done_valid !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL rc10_start got=%b%b want=01", done_valid, busy); end
        count_en(n);
        total++; if (n !== 10) begin bad++; $display("FAIL rc10_len got=%0d want=10", n); end
        total++; if (cycle_count !== 32'd10) begin bad++; $display("FAIL rc10_cyc got=%0d want=10", cycle_count); end
        total++; if (done_valid !== 1'b1 || done_cause !== 2'd0) begin
            bad++; $display("FAIL rc10_done got=%b/%0d want=1/0", done_valid, done_cause); end
        send(3'd2, 32'd0);
        total++; if (clk_core_en !== 1'b0 || done_valid !== 1'b1 || done_cause !== 2'd0 || cycle_count !== 32'd10) begin
            bad++; $display("FAIL rc0 got en=%b dv=%b c=%0d cyc=%0d want 0 1 0 10", clk_core_en, done_valid, done_cause, cycle_count); end
    endtask

    task automatic test_breakpoint;
        int en_before;
        send(3'd6, 32'd0);
        send(3'd3, 32'h40);
        en_before = 0;
        for (int i = 1; i <= 16; i++) begin
            if (i == 16) en_before = clk_core_en;
            rvfi_valid    = 1'b1;
            rvfi_pc_wdata = 32'(i * 4);
            @(negedge clk);
        end
        rvfi_valid = 1'b0;
        total++; if (en_before !== 1) begin bad++; $display("FAIL bp_pre_en got=%0d want=1", en_before); end
        total++; if (clk_core_en !== 1'b0 || done_cause !== 2'd1 || done_valid !== 1'b1) begin
            bad++; $display("FAIL bp_stop got en=%b c=%0d dv=%b want 0 1 1", clk_core_en, done_cause, done_valid); end
        total++; if (retired_count !== 32'd16 || cycle_count !== 32'd16) begin
            bad++; $display("FAIL bp_counts got=%0d/%0d want=16/16", retired_count, cycle_count); end
    endtask

    task automatic test_step;
        logic pat [3];
        send(3'd6, 32'd0);
        send(3'd4, 32'd3);
        rvfi_valid = 1'b1;
        @(negedge clk);
        rvfi_trap = 1'b1;
        @(negedge clk);
        rvfi_valid = 1'b0;
        rvfi_trap  = 1'b0;
        total++; if (clk_core_en !== 1'b0 || done_cause !== 2'd2 || retired_count !== 32'd2) begin
            bad++; $display("FAIL step_trap got en=%b c=%0d ret=%0d want 0 2 2", clk_core_en, done_cause, retired_count); end
        send(3'd3, 32'h100);
        rvfi_valid = 1'b1; rvfi_trap = 1'b1; rvfi_pc_wdata = 32'h100;
        @(negedge clk);
        rvfi_valid = 1'b0; rvfi_trap = 1'b0;
        total++; if (clk_core_en !== 1'b0 || done_cause !== 2'd2) begin
            bad++; $display("FAIL trap_bp got en=%b c=%0d want 0 2", clk_core_en, done_cause); end
        send(3'd6, 32'd0);
        send(3'd4, 32'd2);
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rvfi_valid = pat[i];
            @(negedge clk);
        end
        rvfi_valid = 1'b0;
        total++; if (clk_core_en !== 1'b0 || done_cause !== 2'd0 || retired_count !== 32'd2 || cycle_count !== 32'd3) begin
            bad++; $display("FAIL step2 got en=%b c=%0d ret=%0d cyc=%0d want 0 0 2 3", clk_core_en, done_cause, retired_count, cycle_count); end
        send(3'd4, 32'd1);
        cmd_valid = 1'b1; cmd_op = 3'd5; rvfi_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 3'd0; rvfi_valid = 1'b0;
        total++; if (clk_core_en !== 1'b0 || done_cause !== 2'd0) begin
            bad++; $display("FAIL cnt_vs_halt got en=%b c=%0d want 0 0", clk_core_en, done_cause); end
    endtask

    task automatic test_mid_run;
        send(3'd6, 32'd0);
        send(3'd2, 32'd1000);
        send(3'd2, 32'd5);
        total++; if (cmd_error !== 1'b1 || clk_core_en !== 1'b1) begin
            bad++; $display("FAIL mid_err got err=%b en=%b want 1 1", cmd_error, clk_core_en); end
        @(negedge clk);
        total++; if (cmd_error !== 1'b0 || clk_core_en !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL mid_cont got err=%b en=%b busy=%b want 0 1 1", cmd_error, clk_core_en, busy); end
        send(3'd5, 32'd0);
        total++; if (clk_core_en !== 1'b0 || done_cause !== 2'd3 || done_valid !== 1'b1 || cycle_count !== 32'd5) begin
            bad++; $display("FAIL halt got en=%b c=%0d dv=%b cyc=%0d want 0 3 1 5", clk_core_en, done_cause, done_valid, cycle_count); end
        send(3'd6, 32'd0);
        total++; if (cycle_count !== 32'd0 || retired_count !== 32'd0) begin
            bad++; $display("FAIL clear got=%0d/%0d want=0/0", cycle_count, retired_count); end
        send(3'd7, 32'd0);
        total++; if (cmd_error !== 1'b1) begin bad++; $display("FAIL op7 got=%b want=1", cmd_error); end
    endtask

    task automatic test_async_reset;
        send(3'd3, 32'hdead_beef);
        rvfi_valid = 1'b1; rvfi_pc_wdata = 32'h4;
        repeat (3) @(negedge clk);
        rvfi_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        total++; if (clk_core_en !== 1'b0 || reset_core !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++; $display("FAIL arst_ctl got en=%b rc=%b busy=%b rdy=%b want 0 1 0 1", clk_core_en, reset_core, busy, cmd_ready); end
        total++; if (cycle_count !== 32'd0 || retired_count !== 32'd0) begin
            bad++; $display("FAIL arst_cnt got=%0d/%0d want=0/0", cycle_count, retired_count); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_reset_core();
        test_run_cycles();
        test_breakpoint();
        test_step();
        test_mid_run();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
